// File: rtl/prelude_program_loader.sv
// Serial program loader for the Prelude CPU.
// Receives an 8N1 UART frame (sync, length, payload, checksum) and writes the
// payload into program memory at sequential addresses. The CPU is held in
// reset from sync acceptance until the checksum verifies; a failed load keeps
// it in reset until a later good load or a global reset.
module prelude_program_loader #(
    parameter int         CLKS_PER_BIT = 234,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_reset,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        GET_LEN,
        GET_DATA,
        GET_SUM
    } ld_state_t;

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic rx_meta_d, rx_meta_q;
    logic rx_sync_d, rx_sync_q;

    // Next values for the two synchronizer stages.
    always_comb begin
        rx_meta_d = rx;
        rx_sync_d = rx_meta_q;
    end

    // Synchronizer flops reset to the idle-high line level so no false start
    // is seen when reset drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
        end
    end

    // ------------------------------------------------------------------
    // Byte receiver
    // ------------------------------------------------------------------
    rx_state_t        rx_state_d, rx_state_q;
    logic [CNT_W-1:0] rx_cnt_d, rx_cnt_q;
    logic [2:0]       rx_bit_d, rx_bit_q;
    logic [7:0]       rx_shift_d, rx_shift_q;
    logic             byte_valid_d, byte_valid_q;
    logic             frame_err_d, frame_err_q;

    // Receiver next-state: mid-bit sampling driven by a down-counter that is
    // reloaded with a half bit after the start edge and a full bit thereafter.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = HALF_LAST;
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    if (rx_sync_q) begin
                        // Line went back high before mid-start: a glitch.
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = BIT_LAST;
                        rx_bit_d   = 3'd0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_cnt_d   = BIT_LAST;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_ONE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // Receiver control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= 3'd0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Received-byte shift register; only read when byte_valid_q is high.
    always_ff @(posedge clk) begin
        rx_shift_q <= rx_shift_d;
    end

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    ld_state_t  ld_state_d, ld_state_q;
    logic [8:0] remaining_d, remaining_q;
    logic [7:0] sum_d, sum_q;
    logic       mem_we_d, mem_we_q;
    logic [7:0] mem_addr_d, mem_addr_q;
    logic [7:0] mem_wdata_d, mem_wdata_q;
    logic       cpu_reset_d, cpu_reset_q;
    logic       busy_d, busy_q;
    logic       done_d, done_q;
    logic       error_d, error_q;

    // Loader next-state: frame parsing, memory strobe, checksum and status.
    always_comb begin
        ld_state_d  = ld_state_q;
        remaining_d = remaining_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_reset_d = cpu_reset_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;

        // The address advances in the cycle after each write strobe, so the
        // strobe itself always presents the address being written.
        if (mem_we_q) begin
            mem_addr_d = mem_addr_q + 8'd1;
        end

        case (ld_state_q)
            WAIT_SYNC: begin
                if (byte_valid_q && (rx_shift_q == SYNC_BYTE)) begin
                    error_d     = 1'b0;
                    busy_d      = 1'b1;
                    cpu_reset_d = 1'b1;
                    sum_d       = 8'd0;
                    mem_addr_d  = 8'd0;
                    ld_state_d  = GET_LEN;
                end
            end
            GET_LEN: begin
                if (byte_valid_q) begin
                    // A length byte of zero encodes a full 256-byte image.
                    remaining_d = (rx_shift_q == 8'd0) ? 9'd256 : {1'b0, rx_shift_q};
                    ld_state_d  = GET_DATA;
                end
            end
            GET_DATA: begin
                if (byte_valid_q) begin
                    mem_wdata_d = rx_shift_q;
                    mem_we_d    = 1'b1;
                    sum_d       = sum_q + rx_shift_q;
                    remaining_d = remaining_q - 9'd1;
                    if (remaining_q == 9'd1) begin
                        ld_state_d = GET_SUM;
                    end
                end
            end
            GET_SUM: begin
                if (byte_valid_q) begin
                    if (rx_shift_q == sum_q) begin
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                    busy_d     = 1'b0;
                    ld_state_d = WAIT_SYNC;
                end
            end
            default: begin
                ld_state_d = WAIT_SYNC;
            end
        endcase

        // A broken byte inside a frame aborts the load; the CPU stays held.
        // Outside a frame it is just line noise.
        if (frame_err_q && (ld_state_q != WAIT_SYNC)) begin
            error_d    = 1'b1;
            busy_d     = 1'b0;
            ld_state_d = WAIT_SYNC;
        end
    end

    // Loader control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_state_q  <= WAIT_SYNC;
            remaining_q <= 9'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 8'd0;
            mem_wdata_q <= 8'd0;
            cpu_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            ld_state_q  <= ld_state_d;
            remaining_q <= remaining_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Running checksum; cleared on every accepted sync byte.
    always_ff @(posedge clk) begin
        sum_q <= sum_d;
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_prelude_program_loader.sv
// Testbench for prelude_program_loader: drives UART frames into rx and
// compares memory writes and status against a frame-level reference model.
module tb_prelude_program_loader;

    localparam int         CPB  = 4;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic       error;

    prelude_program_loader #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (SYNC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       bad;
    } item_t;

    item_t       seq[$];
    logic [15:0] exp_wq[$];

    int checks = 0;
    int errors = 0;

    // Reference model state (what the loader should show after the bytes so far).
    bit         m_error = 1'b0;
    bit         m_cpu   = 1'b0;
    bit         m_busy  = 1'b0;
    logic [7:0] m_addr  = 8'd0;
    int         m_done_exp = 0;
    int         done_cnt   = 0;

    int cycle         = 0;
    int last_we_cycle = -1000;
    bit prev_we       = 1'b0;

    // Scoreboard: every write strobe is matched against the model's queue.
    always @(negedge clk) begin
        cycle++;
        if (mem_we === 1'b1) begin
            checks++;
            if (prev_we || (cycle - last_we_cycle) < 10 * CPB) begin
                errors++;
                $display("FAIL we_spacing: gap %0d cycles, required >= %0d and not back-to-back",
                         cycle - last_we_cycle, 10 * CPB);
            end
            checks++;
            if (exp_wq.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                logic [15:0] e;
                e = exp_wq.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_wdata, e[15:8], e[7:0]);
                end
            end
            last_we_cycle = cycle;
        end
        prev_we = (mem_we === 1'b1);
        if (done === 1'b1) begin
            done_cnt++;
            checks++;
            if ({error, cpu_reset, busy} !== 3'b000) begin
                errors++;
                $display("FAIL done_status: got error/cpu_reset/busy=%b, required 000", {error, cpu_reset, busy});
            end
        end
    end

    task automatic push_b(input logic [7:0] d, input logic b);
        item_t it;
        it.data = d;
        it.bad  = b;
        seq.push_back(it);
    endtask

    // Frame-level model: hunt for sync, read length, data, checksum.
    task automatic model_run();
        int         i;
        int         n;
        int         len;
        bit         ok;
        logic [7:0] sum;
        item_t      b;
        i = 0;
        n = seq.size();
        sum = 8'd0;
        while (i < n) begin
            b = seq[i]; i++;
            if (b.bad || b.data != SYNC) continue;
            m_error = 1'b0; m_busy = 1'b1; m_cpu = 1'b1; m_addr = 8'd0; sum = 8'd0;
            if (i >= n) return;
            b = seq[i]; i++;
            if (b.bad) begin m_error = 1'b1; m_busy = 1'b0; continue; end
            len = (b.data == 8'd0) ? 256 : int'(b.data);
            ok = 1'b1;
            for (int k = 0; k < len; k++) begin
                if (i >= n) return;
                b = seq[i]; i++;
                if (b.bad) begin m_error = 1'b1; m_busy = 1'b0; ok = 1'b0; break; end
                exp_wq.push_back({m_addr, b.data});
                sum = sum + b.data;
                m_addr = m_addr + 8'd1;
            end
            if (!ok) continue;
            if (i >= n) return;
            b = seq[i]; i++;
            if (b.bad || b.data != sum) begin
                m_error = 1'b1; m_busy = 1'b0;
            end else begin
                m_done_exp++; m_cpu = 1'b0; m_busy = 1'b0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad, input int gap);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (CPB) @(negedge clk);
        end
        rx = bad ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_seq(input int max_gap);
        for (int i = 0; i < seq.size(); i++) begin
            int gap;
            gap = seq[i].bad ? 3 * CPB : int'($urandom_range(0, max_gap));
            send_byte(seq[i].data, seq[i].bad, gap);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b, required 0", mem_we); end
        checks++;
        if ({mem_addr, mem_wdata} !== 16'h0000) begin errors++; $display("FAIL reset_addr_data: got %h, required 0000", {mem_addr, mem_wdata}); end
        checks++;
        if ({cpu_reset, busy, done, error} !== 4'b0000) begin errors++; $display("FAIL reset_status: got %b, required 0000", {cpu_reset, busy, done, error}); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({mem_we, cpu_reset, busy, done, error} !== 5'b00000) begin errors++; $display("FAIL post_reset_status: got %b, required 00000", {mem_we, cpu_reset, busy, done, error}); end
        m_error = 1'b0; m_cpu = 1'b0; m_busy = 1'b0; m_addr = 8'd0;
    endtask

    task automatic test_good_load();
        seq.delete(); done_cnt = 0; m_done_exp = 0;
        push_b(8'hA5, 0); push_b(8'h03, 0); push_b(8'h10, 0);
        push_b(8'h20, 0); push_b(8'h30, 0); push_b(8'h60, 0);
        model_run();
        send_seq(3);
        checks++;
        if (done_cnt !== 1 || m_done_exp !== 1) begin errors++; $display("FAIL good_done: got %0d pulses, required 1", done_cnt); end
        checks++;
        if ({error, cpu_reset, busy} !== 3'b000) begin errors++; $display("FAIL good_status: got %b, required 000", {error, cpu_reset, busy}); end
        checks++;
        if (mem_addr !== 8'h03 || exp_wq.size() != 0) begin errors++; $display("FAIL good_addr: got addr=%h pending=%0d, required 03 and 0", mem_addr, exp_wq.size()); end
    endtask

    task automatic test_bad_checksum();
        for (int ph = 0; ph < 2; ph++) begin
            seq.delete(); done_cnt = 0; m_done_exp = 0;
            if (ph == 0) begin
                push_b(8'hA5, 0); push_b(8'h02, 0); push_b(8'h01, 0); push_b(8'h02, 0); push_b(8'h04, 0);
            end else begin
                push_b(8'hA5, 0); push_b(8'h01, 0); push_b(8'h07, 0); push_b(8'h07, 0);
            end
            model_run();
            send_seq(3);
            checks++;
            if (done_cnt !== m_done_exp) begin errors++; $display("FAIL badsum_done ph%0d: got %0d, required %0d", ph, done_cnt, m_done_exp); end
            checks++;
            if ({error, cpu_reset, busy} !== {m_error, m_cpu, m_busy}) begin errors++; $display("FAIL badsum_status ph%0d: got %b, required %b", ph, {error, cpu_reset, busy}, {m_error, m_cpu, m_busy}); end
            checks++;
            if (mem_addr !== m_addr || exp_wq.size() != 0) begin errors++; $display("FAIL badsum_addr ph%0d: got %h pending=%0d, required %h and 0", ph, mem_addr, exp_wq.size(), m_addr); end
        end
    endtask

    task automatic test_len0();
        seq.delete(); done_cnt = 0; m_done_exp = 0;
        push_b(8'hA5, 0); push_b(8'h00, 0);
        for (int i = 0; i < 256; i++) push_b(8'(i), 0);
        push_b(8'h80, 0);
        model_run();
        send_seq(0);
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL len0_done: got %0d, required 1", done_cnt); end
        checks++;
        if (mem_addr !== 8'h00 || exp_wq.size() != 0) begin errors++; $display("FAIL len0_addr: got %h pending=%0d, required 00 and 0", mem_addr, exp_wq.size()); end
        checks++;
        if ({error, cpu_reset, busy} !== 3'b000) begin errors++; $display("FAIL len0_status: got %b, required 000", {error, cpu_reset, busy}); end
    endtask

    task automatic test_noise_framing();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if ({error, cpu_reset, busy} !== {m_error, m_cpu, m_busy} || exp_wq.size() != 0) begin
            errors++; $display("FAIL glitch: got %b, required %b", {error, cpu_reset, busy}, {m_error, m_cpu, m_busy});
        end
        seq.delete(); done_cnt = 0; m_done_exp = 0;
        push_b(8'hA5, 0); push_b(8'h03, 0); push_b(8'h11, 0); push_b(8'h22, 1);
        model_run();
        send_seq(2);
        checks++;
        if ({error, cpu_reset, busy} !== 3'b110) begin errors++; $display("FAIL framing_status: got %b, required 110", {error, cpu_reset, busy}); end
        checks++;
        if (done_cnt !== 0 || exp_wq.size() != 0 || mem_addr !== m_addr) begin errors++; $display("FAIL framing_writes: got done=%0d pending=%0d addr=%h, required 0 0 %h", done_cnt, exp_wq.size(), mem_addr, m_addr); end
    endtask

    task automatic test_reset_midload();
        seq.delete(); done_cnt = 0; m_done_exp = 0;
        push_b(8'hA5, 0); push_b(8'h04, 0);
        push_b(8'($urandom_range(0, 255)), 0); push_b(8'($urandom_range(0, 255)), 0);
        model_run();
        send_seq(2);
        checks++;
        if ({cpu_reset, busy} !== 2'b11 || exp_wq.size() != 0) begin errors++; $display("FAIL midload_pre: got cpu_reset/busy=%b pending=%0d, required 11 and 0", {cpu_reset, busy}, exp_wq.size()); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, error} !== 21'd0) begin
            errors++; $display("FAIL midload_reset: got we=%b addr=%h data=%h status=%b, required all 0", mem_we, mem_addr, mem_wdata, {cpu_reset, busy, done, error});
        end
        reset = 1'b0;
        m_error = 1'b0; m_cpu = 1'b0; m_busy = 1'b0; m_addr = 8'd0;
        repeat (10) @(negedge clk);
        seq.delete(); done_cnt = 0; m_done_exp = 0;
        push_b(8'hA5, 0); push_b(8'h03, 0); push_b(8'h01, 0); push_b(8'hA5, 0); push_b(8'h40, 0); push_b(8'hE6, 0);
        model_run();
        send_seq(3);
        checks++;
        if (done_cnt !== 1 || mem_addr !== 8'h03 || exp_wq.size() != 0) begin errors++; $display("FAIL midload_reload: got done=%0d addr=%h pending=%0d, required 1 03 0", done_cnt, mem_addr, exp_wq.size()); end
    endtask

    task automatic test_presync_garbage();
        seq.delete(); done_cnt = 0; m_done_exp = 0;
        push_b(8'h00, 0); push_b(8'hFF, 0); push_b(8'h5A, 0);
        push_b(8'hA5, 0); push_b(8'h02, 0); push_b(8'h33, 0); push_b(8'h44, 0); push_b(8'h77, 0);
        model_run();
        send_seq(3);
        checks++;
        if (done_cnt !== 1 || {error, cpu_reset, busy} !== 3'b000) begin errors++; $display("FAIL garbage: got done=%0d status=%b, required 1 000", done_cnt, {error, cpu_reset, busy}); end
        checks++;
        if (mem_addr !== 8'h02 || exp_wq.size() != 0) begin errors++; $display("FAIL garbage_addr: got %h pending=%0d, required 02 0", mem_addr, exp_wq.size()); end
    endtask

    task automatic test_random_frames(input int max_gap);
        logic [7:0] g;
        logic [7:0] s;
        int         len;
        for (int f = 0; f < 6; f++) begin
            seq.delete(); done_cnt = 0; m_done_exp = 0;
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                g = 8'($urandom_range(0, 255));
                if (g == SYNC) g = 8'h00;
                push_b(g, 0);
            end
            len = int'($urandom_range(1, 6));
            push_b(SYNC, 0);
            push_b(8'(len), 0);
            s = 8'd0;
            for (int k = 0; k < len; k++) begin
                g = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom_range(0, 255));
                push_b(g, 0);
                s = s + g;
            end
            if ($urandom_range(0, 2) == 0) s = s ^ 8'($urandom_range(1, 255));
            push_b(s, 0);
            model_run();
            send_seq(max_gap);
            checks++;
            if (done_cnt !== m_done_exp) begin errors++; $display("FAIL rand_done f%0d: got %0d, required %0d", f, done_cnt, m_done_exp); end
            checks++;
            if ({error, cpu_reset, busy} !== {m_error, m_cpu, m_busy}) begin errors++; $display("FAIL rand_status f%0d: got %b, required %b", f, {error, cpu_reset, busy}, {m_error, m_cpu, m_busy}); end
            checks++;
            if (mem_addr !== m_addr || exp_wq.size() != 0) begin errors++; $display("FAIL rand_addr f%0d: got %h pending=%0d, required %h 0", f, mem_addr, exp_wq.size(), m_addr); end
        end
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_noise_framing();
        test_presync_garbage();
        test_reset_midload();
        test_random_frames(4);
        test_random_frames(0);
        test_len0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prelude_program_loader.md
Name: prelude_program_loader

Overview:
- Serial bootloader that writes the Prelude program memory, the write-side counterpart of the CPU's instruction fetch port.
- Receives an 8N1 UART byte stream from a host and writes each payload byte to program memory at sequential addresses.
- Holds the CPU in reset while loading. Releases it only after the checksum verifies.
- Sits between the board rx pin and the program memory write port; cpu_reset is ORed into the prelude reset at top level.

Parameters:
CLKS_PER_BIT, 234, clk cycles per UART bit (27 MHz / 115200); must be >= 4
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
rx  in  1  asynchronous UART line, idle high
mem_we  out  1  one-cycle program-memory write strobe
mem_addr  out  8  write address
mem_wdata  out  8  write data
cpu_reset  out  1  high while a load is in progress or failed
busy  out  1  high from sync accepted to frame end
done  out  1  one-cycle pulse on successful load
error  out  1  sticky load failure flag

Behaviour:
- Reset values: all outputs are 0, the FSM is in WAIT_SYNC, and the byte receiver is in RX_IDLE. The CPU runs the existing memory contents after reset.
- rx passes through a 2-flop synchronizer before any use. This adds 2 cycles of input latency.
- Byte receiver FSM: RX_IDLE -> RX_START -> RX_DATA -> RX_STOP -> RX_IDLE.
  - RX_IDLE: a synchronized low level enters RX_START and loads the bit counter.
  - RX_START: rx is sampled at CLKS_PER_BIT/2 (integer division). If rx is high, the start is false: return to RX_IDLE with no byte and no error.
  - RX_DATA: 8 samples, each CLKS_PER_BIT apart, LSB first.
  - RX_STOP: the stop bit is sampled one CLKS_PER_BIT later. If high, byte_valid pulses for 1 cycle. If low, this is a framing error.
- Loader FSM: WAIT_SYNC, GET_LEN, GET_DATA, GET_SUM.
  - WAIT_SYNC: a byte equal to SYNC_BYTE clears error, sets busy and cpu_reset, clears sum, and sets mem_addr to 0, then goes to GET_LEN. Any other byte is ignored.
  - GET_LEN: the byte is latched as remaining count N. A value of 0 means 256. Go to GET_DATA.
  - GET_DATA: on each byte, mem_wdata <= byte and mem_we <= 1 for exactly the cycle after byte_valid. mem_addr holds the current address during that strobe. The sum accumulates the byte mod 256. mem_addr increments the cycle after the strobe and wraps 255 -> 0. Remaining count decrements; when the last byte is written, go to GET_SUM.
  - GET_SUM: if the byte equals the sum, then in the cycle after byte_valid: done pulses, cpu_reset <= 0, busy <= 0. If it mismatches: error <= 1, busy <= 0, cpu_reset stays 1. Either way, go to WAIT_SYNC.
- Framing error in GET_LEN, GET_DATA or GET_SUM: error <= 1, busy <= 0, cpu_reset stays 1, go to WAIT_SYNC. A framing error in WAIT_SYNC is silently ignored.
- Bytes already written before an error stay written. The CPU stays in reset until a later good load or a global reset.
- A SYNC_BYTE value arriving inside GET_LEN, GET_DATA or GET_SUM is data, not a restart.
- mem_we is never high in two consecutive cycles. Write strobes are at least 10*CLKS_PER_BIT apart.
- reset asserted mid-frame aborts immediately to reset values and releases cpu_reset. mem_we is 0 in the reset cycle and after.
- done and error are never high in the same cycle.

Test Plan:
- Good load (CLKS_PER_BIT=4): send A5, 03, 10, 20, 30, 60 -> three writes, (00,10), (01,20), (02,30), one cycle each. Then done pulses once, cpu_reset falls with done, error=0.
- Bad checksum: send A5, 02, 01, 02, 04 -> writes to addresses 00 and 01. Then error=1, done never pulses, cpu_reset stays 1. A following good frame clears error and ends with done.
- Length 0: send A5, 00, then 256 bytes of value i, then checksum 80 -> writes at addresses 00..FF, mem_addr wraps to 00 afterwards, done pulses.
- Noise and framing: a 1-cycle rx low glitch in WAIT_SYNC gives no byte and no state change. A byte with stop bit 0 during GET_DATA sets error=1, returns to WAIT_SYNC, and cpu_reset stays 1.
- Reset mid-load: assert reset after the 2nd data byte of a 4-byte frame -> next cycle all outputs 0. A subsequent full frame loads correctly from address 00.
- Pre-sync garbage: send 00, FF, 5A, then a good frame -> the first three bytes cause no writes and no error, and the load completes normally.
